dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
Word-addressed data-memory responder: the memory-side end of the pipelined CPU's MEM-stage load/store request interface. It captures a request, inserts a programmable number of wait states, then commits the store or returns the load word with a one-cycle Ack. The CPU stalls its MEM stage on Busy/Ack. It also gives the CPU bench a realistic, non-zero-latency memory for exercising stall logic.

Parameters:
DEPTH_LOG2, 8, log2 of memory depth in 32-bit words (256 words).
WAIT, 2, wait-state cycles between request capture and response (0 allowed).

Ports:
Clk  in  1  single clock; all state updates on the rising edge.
Clr  in  1  reset, synchronous and active-high.
Req  in  1  request valid; held by the initiator until it sees Ack.
We  in  1  1 = store, 0 = load.
Addr  in  32  byte address; must be word-aligned.
Wdata  in  32  store data.
Be  in  4  byte enables for stores; Be[i] selects Wdata[8i+7:8i].
Ack  out  1  one-cycle response strobe.
Rdata  out  32  load data, valid while Ack=1 and held afterwards.
Err  out  1  error flag, qualified by Ack.
Busy  out  1  high while a request is in flight (state != IDLE).

Behaviour:
- Reset (Clr=1 at an edge): state=IDLE, Ack=0, Rdata=0, Err=0, Busy=0, wait counter=0. Memory array contents are not cleared.
- Reset mid-operation: any in-flight request is aborted and its store is never committed. Clr has priority over all other inputs.
- States: IDLE, WAIT, RESP.
- IDLE:
  - Req=1 at an edge captures We, Addr, Wdata and Be into holding registers.
  - Next state is WAIT with counter=WAIT-1 if WAIT>0; otherwise RESP.
- WAIT: counter decrements each cycle. When counter=0, next state is RESP.
- Inputs after capture: changes to Req, We, Addr, Wdata or Be are ignored; only the captured values are used.
- Entering RESP (single edge): the operation executes.
  - Store: each byte lane with Be[i]=1 is written; other lanes are unchanged. Be=0000 is a legal no-op store and is still acked. Rdata is unchanged.
  - Load: Rdata is loaded with mem[Addr[DEPTH_LOG2+1:2]]. Be is ignored and the full word is returned.
- RESP: lasts one cycle with Ack=1 (registered output). Next state is always IDLE.
- Ack timing: with Req sampled at edge 0, Ack is high in cycle WAIT+1 (WAIT=2 gives Ack in the 3rd cycle after capture).
- Initiator handshake: the initiator deasserts Req, or presents a new request, in the cycle after Ack. Responder throughput is one request per WAIT+2 cycles.
- Error detection, evaluated on the captured address:
  - misaligned: Addr[1:0] != 0;
  - out of range: Addr[31:DEPTH_LOG2+2] != 0.
  - On error: no memory write, Rdata is set to 0, and Err=1 together with Ack.
- Err is 0 in every cycle where Ack=0, and 0 on good responses.
- Rdata holds its last value until the next load or error response.
- Busy: 1 in WAIT and RESP, 0 in IDLE. It is a combinational decode of the state register.
- Req=0 in IDLE: remain in IDLE with all outputs stable.

Test Plan:
1. Reset and store/load (WAIT=2): assert Clr for 2 cycles and check Ack=Err=Busy=0 and Rdata=0. Then store Addr=0x10, Wdata=0xDEADBEEF, Be=1111 and check Ack exactly 3 cycles after capture. Then load 0x10 and check Rdata=0xDEADBEEF with Ack, Err=0.
2. Byte lanes: starting from 0xDEADBEEF at 0x10, store Wdata=0x11223344 with Be=0101, then load 0x10 and check Rdata=0xDE22BE44. Then store with Be=0000 and check Ack still arrives and a reload returns 0xDE22BE44.
3. Errors: load 0x12 gives Ack, Err=1, Rdata=0. Store to 0x400 (DEPTH_LOG2=8) gives Err=1 and no wrap to word 0: reload 0x0 and check it is unchanged.
4. Reset mid-operation: store 0xCAFEF00D to 0x20, then assert Clr during WAIT. Check Busy=0 next cycle and no Ack. Reload 0x20 and check the old value.
5. WAIT=0 back-to-back: two loads with Req held continuously give Ack every 2nd cycle, and Busy toggles 1 in RESP only.
6. Input churn: change Addr/Wdata during WAIT and check the response uses the captured values.

Source files
------------

// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder for the CPU MEM stage.
// Captures a load/store, waits WAIT cycles, then commits or returns data with a one-cycle Ack.
module dmem_responder #(
    parameter int DEPTH_LOG2 = 8,
    parameter int WAIT       = 2
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic        Req,
    input  logic        We,
    input  logic [31:0] Addr,
    input  logic [31:0] Wdata,
    input  logic [3:0]  Be,
    output logic        Ack,
    output logic [31:0] Rdata,
    output logic        Err,
    output logic        Busy,
    output logic [1:0]  Dbg_state
);

    // Handshake: Req is sampled only in IDLE; the request is captured on that edge and
    // the initiator holds it until Ack, then drops it or presents the next request.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int CW = (WAIT > 1) ? $clog2(WAIT) : 1;
    localparam logic [CW-1:0] CNT_INIT = (WAIT > 0) ? CW'(WAIT - 1) : '0;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;

    logic             r_we;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [3:0]       r_be;

    logic             r_ack;
    logic             r_err;
    logic [31:0]      r_rdata;
    logic [31:0]      r_mem [2**DEPTH_LOG2];

    logic             w_capture;
    logic             w_op_we;
    logic [31:0]      w_op_addr;
    logic [31:0]      w_op_wdata;
    logic [3:0]       w_op_be;
    logic             w_exec;
    logic             w_bad;
    logic [DEPTH_LOG2-1:0] w_idx;

    always_ff @(posedge Clk) begin
        if (Clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (Req) begin
                    if (WAIT == 0) begin
                        w_next = S_RESP;
                    end else begin
                        w_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_next = S_RESP;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        Busy      = (r_state != S_IDLE);
        Ack       = r_ack;
        Err       = r_err;
        Rdata     = r_rdata;
        Dbg_state = r_state;
    end

    assign w_capture = (r_state == S_IDLE) && Req;

    always_ff @(posedge Clk) begin
        if (Clr) begin
            r_cnt <= '0;
        end else if (w_capture) begin
            r_cnt <= CNT_INIT;
        end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (w_capture) begin
            r_we    <= We;
            r_addr  <= Addr;
            r_wdata <= Wdata;
            r_be    <= Be;
        end
    end

    // With WAIT=0 the operation executes on the capture edge, so it reads the live inputs.
    assign w_op_we    = (r_state == S_IDLE) ? We    : r_we;
    assign w_op_addr  = (r_state == S_IDLE) ? Addr  : r_addr;
    assign w_op_wdata = (r_state == S_IDLE) ? Wdata : r_wdata;
    assign w_op_be    = (r_state == S_IDLE) ? Be    : r_be;

    assign w_exec = (w_next == S_RESP) && !Clr;
    assign w_bad  = (w_op_addr[1:0] != 2'b00) || (w_op_addr[31:DEPTH_LOG2+2] != '0);
    assign w_idx  = w_op_addr[DEPTH_LOG2+1:2];

    always_ff @(posedge Clk) begin
        if (w_exec && w_op_we && !w_bad) begin
            for (int i = 0; i < 4; i++) begin
                if (w_op_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_op_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack <= w_exec;
            r_err <= w_exec && w_bad;
            if (w_exec && w_bad) begin
                r_rdata <= '0;
            end else if (w_exec && !w_op_we) begin
                r_rdata <= r_mem[w_idx];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with WAIT=2 and one with WAIT=0, checked every
// cycle against a transaction-level model (capture cycle + latency, word array, held Rdata).
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // stimulus, index 0 = WAIT=2 instance, index 1 = WAIT=0 instance
    logic        clr   [2];
    logic        req   [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [3:0]  be    [2];

    logic        ack0, ack1, err0, err1, busy0, busy1;
    logic [31:0] rdata0, rdata1;
    logic [1:0]  st0, st1;

    logic        ack   [2];
    logic        err   [2];
    logic        busy  [2];
    logic [31:0] rdata [2];

    always_comb begin
        ack[0] = ack0;   ack[1] = ack1;
        err[0] = err0;   err[1] = err1;
        busy[0] = busy0; busy[1] = busy1;
        rdata[0] = rdata0; rdata[1] = rdata1;
    end

    dmem_responder #(.DEPTH_LOG2(8), .WAIT(2)) dut_w2 (
        .Clk(clk), .Clr(clr[0]), .Req(req[0]), .We(we[0]), .Addr(addr[0]),
        .Wdata(wdata[0]), .Be(be[0]), .Ack(ack0), .Rdata(rdata0), .Err(err0),
        .Busy(busy0), .Dbg_state(st0)
    );

    dmem_responder #(.DEPTH_LOG2(8), .WAIT(0)) dut_w0 (
        .Clk(clk), .Clr(clr[1]), .Req(req[1]), .We(we[1]), .Addr(addr[1]),
        .Wdata(wdata[1]), .Be(be[1]), .Ack(ack1), .Rdata(rdata1), .Err(err1),
        .Busy(busy1), .Dbg_state(st1)
    );

    int waits [2] = '{2, 0};

    // behavioural model
    logic [31:0] m_mem   [2][256];
    logic [31:0] m_rdata [2];
    bit          p_v     [2];
    int          p_cap   [2];
    int          p_ack   [2];
    logic        p_we    [2];
    logic [31:0] p_addr  [2];
    logic [31:0] p_wdata [2];
    logic [3:0]  p_be    [2];
    int          last_ack[2];
    bit          chk_en = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    logic        e_ack, e_busy, e_err, e_bad;
    logic [31:0] ma;

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                e_ack  = p_v[k] && (cyc == p_ack[k]);
                e_busy = p_v[k] && (cyc >= p_cap[k]) && (cyc <= p_ack[k]);
                e_err  = 1'b0;
                if (e_ack) begin
                    ma    = p_addr[k];
                    e_bad = (ma[1:0] != 2'b00) || (ma[31:10] != 22'd0);
                    if (e_bad) begin
                        e_err      = 1'b1;
                        m_rdata[k] = 32'd0;
                    end else if (p_we[k]) begin
                        for (int i = 0; i < 4; i++)
                            if (p_be[k][i]) m_mem[k][ma[9:2]][8*i +: 8] = p_wdata[k][8*i +: 8];
                    end else begin
                        m_rdata[k] = m_mem[k][ma[9:2]];
                    end
                end
                chk($sformatf("ack%0d", k),   32'(ack[k]),  32'(e_ack));
                chk($sformatf("busy%0d", k),  32'(busy[k]), 32'(e_busy));
                chk($sformatf("err%0d", k),   32'(err[k]),  32'(e_err));
                chk($sformatf("rdata%0d", k), rdata[k],     m_rdata[k]);
                if (ack[k] === 1'b1) last_ack[k] = cyc;
                if (e_ack) p_v[k] = 1'b0;
            end
        end
    end

    // Drivers run at posedge+2; each returns at posedge+2 of the cycle after the Ack cycle
    // with Req still high, so a following issue() is back-to-back.
    task automatic issue(input int k, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b);
        int ackc;
        we[k] = w; addr[k] = a; wdata[k] = d; be[k] = b; req[k] = 1'b1;
        p_we[k] = w; p_addr[k] = a; p_wdata[k] = d; p_be[k] = b;
        p_cap[k] = cyc + 1;
        p_ack[k] = cyc + 1 + waits[k];
        p_v[k]   = 1'b1;
        ackc     = p_ack[k];
        while (cyc < ackc + 1) begin
            @(posedge clk); #2;
            we[k] = 1'($urandom_range(0, 1));
            addr[k] = $urandom;
            wdata[k] = $urandom;
            be[k] = 4'($urandom_range(0, 15));
        end
    endtask

    task automatic idle(input int k, input int n);
        req[k] = 1'b0;
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic rst(input int k, input int n);
        req[k] = 1'b0;
        clr[k] = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        p_v[k] = 1'b0;
        m_rdata[k] = 32'd0;
        #1;
        clr[k] = 1'b0;
    endtask

    task automatic abort_store(input int k, input logic [31:0] a, input logic [31:0] d);
        we[k] = 1'b1; addr[k] = a; wdata[k] = d; be[k] = 4'hF; req[k] = 1'b1;
        p_we[k] = 1'b1; p_addr[k] = a; p_wdata[k] = d; p_be[k] = 4'hF;
        p_cap[k] = cyc + 1;
        p_ack[k] = cyc + 1 + waits[k];
        p_v[k]   = 1'b1;
        @(posedge clk); #2;
        rst(k, 1);
    endtask

    task automatic fill(input int k);
        for (int w = 0; w < 256; w++) issue(k, 1'b1, 32'(w) << 2, $urandom, 4'hF);
        idle(k, 1);
    endtask

    task automatic rand_ops(input int k, input int n);
        logic [31:0] a;
        int r;
        for (int i = 0; i < n; i++) begin
            a = 32'($urandom_range(0, 255)) << 2;
            r = $urandom_range(0, 15);
            if (r == 0) a[1:0] = 2'($urandom_range(1, 3));
            else if (r == 1) a[31:10] = 22'($urandom_range(1, 32'h3FFFFF));
            issue(k, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 1) == 1) idle(k, $urandom_range(1, 3));
        end
        idle(k, 2);
    endtask

    int first_ack;

    initial begin
        for (int k = 0; k < 2; k++) begin
            clr[k] = 1'b1; req[k] = 1'b0; we[k] = 1'b0;
            addr[k] = '0; wdata[k] = '0; be[k] = '0;
            p_v[k] = 1'b0; m_rdata[k] = '0; last_ack[k] = -1;
        end
        repeat (2) @(posedge clk);
        #1;
        #1;
        clr[0] = 1'b0; clr[1] = 1'b0;
        chk_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            chk("reset_ack",   32'(ack[k]),  32'd0);
            chk("reset_err",   32'(err[k]),  32'd0);
            chk("reset_busy",  32'(busy[k]), 32'd0);
            chk("reset_rdata", rdata[k],     32'd0);
        end

        // ---- WAIT=2 instance ----
        fill(0);
        issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        chk("store_ack_latency", 32'(last_ack[0] - p_cap[0]), 32'd2);
        idle(0, 1);
        issue(0, 1'b0, 32'h10, 32'h0, 4'h0);
        chk("load_full", rdata[0], 32'hDEADBEEF);
        idle(0, 1);
        issue(0, 1'b1, 32'h10, 32'h11223344, 4'b0101);
        issue(0, 1'b0, 32'h10, 32'h0, 4'hF);
        chk("load_lanes", rdata[0], 32'hDE22BE44);
        issue(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000);
        chk("noop_store_acked", 32'(last_ack[0] - p_cap[0]), 32'd2);
        issue(0, 1'b0, 32'h10, 32'h0, 4'hF);
        chk("load_after_noop", rdata[0], 32'hDE22BE44);
        idle(0, 1);
        issue(0, 1'b0, 32'h12, 32'h0, 4'hF);
        chk("misaligned_rdata", rdata[0], 32'h0);
        issue(0, 1'b1, 32'h0, 32'h01234567, 4'hF);
        issue(0, 1'b1, 32'h400, 32'h55AA55AA, 4'hF);
        issue(0, 1'b0, 32'h0, 32'h0, 4'hF);
        chk("no_wrap_word0", rdata[0], 32'h01234567);
        idle(0, 1);
        issue(0, 1'b1, 32'h20, 32'h0BADBEEF, 4'hF);
        idle(0, 1);
        abort_store(0, 32'h20, 32'hCAFEF00D);
        idle(0, 2);
        issue(0, 1'b0, 32'h20, 32'h0, 4'hF);
        chk("abort_no_commit", rdata[0], 32'h0BADBEEF);
        idle(0, 1);
        rand_ops(0, 300);

        // ---- WAIT=0 instance ----
        fill(1);
        issue(1, 1'b1, 32'h40, 32'hA5A5F00F, 4'hF);
        issue(1, 1'b0, 32'h40, 32'h0, 4'hF);
        first_ack = last_ack[1];
        chk("w0_ack_latency", 32'(last_ack[1] - p_cap[1]), 32'd0);
        issue(1, 1'b0, 32'h40, 32'h0, 4'h0);
        chk("w0_b2b_spacing", 32'(last_ack[1] - first_ack), 32'd2);
        chk("w0_load", rdata[1], 32'hA5A5F00F);
        idle(1, 1);
        rand_ops(1, 300);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
